// File: rtl/sram_cache_ctrl_if.sv
// CPU, backing-memory and tag/data SRAM signals of the cache controller.
// The slave modport is the controller's view; master is the surrounding system.
interface sram_cache_ctrl_if #(
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

  logic                   i_flush;
  logic                   i_cpu_req;
  logic                   i_cpu_we;
  logic [ADDR_WIDTH-1:0]  i_cpu_addr;
  logic [DATA_WIDTH-1:0]  i_cpu_wdata;
  logic [DATA_WIDTH-1:0]  o_cpu_rdata;
  logic                   o_cpu_ack;
  logic                   o_mem_req;
  logic                   o_mem_we;
  logic [ADDR_WIDTH-1:0]  o_mem_addr;
  logic [DATA_WIDTH-1:0]  o_mem_wdata;
  logic [DATA_WIDTH-1:0]  i_mem_rdata;
  logic                   i_mem_ack;
  logic [INDEX_WIDTH-1:0] o_dat_addr;
  logic                   o_dat_we;
  logic [DATA_WIDTH-1:0]  o_dat_w;
  logic [DATA_WIDTH-1:0]  i_dat_r;
  logic [INDEX_WIDTH-1:0] o_tag_addr;
  logic                   o_tag_we;
  logic [TAG_WIDTH-1:0]   o_tag_w;
  logic [TAG_WIDTH-1:0]   i_tag_r;

  modport slave (
    input  i_flush, i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_rdata, o_cpu_ack,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata, i_mem_ack,
    output o_dat_addr, o_dat_we, o_dat_w,
    input  i_dat_r,
    output o_tag_addr, o_tag_we, o_tag_w,
    input  i_tag_r
  );

  modport master (
    output i_flush, i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_rdata, o_cpu_ack,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata, i_mem_ack,
    input  o_dat_addr, o_dat_we, o_dat_w,
    output i_dat_r,
    input  o_tag_addr, o_tag_we, o_tag_w,
    output i_tag_r
  );
endinterface

// File: rtl/sram_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller; read hit acks 2 cycles after accept.
// Misses and all writes stall the CPU (no ack) until the backing memory acks; CPU holds its request meanwhile.
module sram_cache_ctrl #(
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6
) (
  input logic               i_ck,
  input logic               i_rst_n,
  sram_cache_ctrl_if.slave  bus
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRMEM} state_t;

  state_t                 state, state_nxt;
  logic [LINES-1:0]       valid;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_we;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   accept;
  logic                   hit;

  assign req_index = req_addr[INDEX_WIDTH-1:0];
  assign req_tag   = req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  // The ack cycle still sees the old request held high, so it is never taken as a new one.
  assign accept = i_rst_n && (state == IDLE) && !bus.i_flush && bus.i_cpu_req && !bus.o_cpu_ack;
  assign hit    = valid[req_index] && (bus.i_tag_r == req_tag);

  always_comb begin
    state_nxt      = state;
    bus.o_dat_addr = '0;
    bus.o_dat_we   = 1'b0;
    bus.o_dat_w    = '0;
    bus.o_tag_addr = '0;
    bus.o_tag_we   = 1'b0;
    bus.o_tag_w    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.o_dat_addr = bus.i_cpu_addr[INDEX_WIDTH-1:0];
          bus.o_tag_addr = bus.i_cpu_addr[INDEX_WIDTH-1:0];
          state_nxt      = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.o_dat_addr = req_index;
        bus.o_tag_addr = req_index;
        if (req_we) begin
          if (hit) begin
            bus.o_dat_we = 1'b1;
            bus.o_dat_w  = req_wdata;
          end
          state_nxt = WRMEM;
        end else begin
          state_nxt = hit ? IDLE : REFILL;
        end
      end
      REFILL: begin
        if (bus.i_mem_ack) begin
          bus.o_dat_addr = req_index;
          bus.o_dat_we   = 1'b1;
          bus.o_dat_w    = bus.i_mem_rdata;
          bus.o_tag_addr = req_index;
          bus.o_tag_we   = 1'b1;
          bus.o_tag_w    = req_tag;
          state_nxt      = IDLE;
        end
      end
      WRMEM: begin
        if (bus.i_mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      valid           <= '0;
      req_addr        <= '0;
      req_we          <= 1'b0;
      req_wdata       <= '0;
      bus.o_cpu_ack   <= 1'b0;
      bus.o_cpu_rdata <= '0;
      bus.o_mem_req   <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
    end else begin
      state         <= state_nxt;
      bus.o_cpu_ack <= 1'b0;
      if (state == IDLE && bus.i_flush) valid <= '0;
      if (accept) begin
        req_addr  <= bus.i_cpu_addr;
        req_we    <= bus.i_cpu_we;
        req_wdata <= bus.i_cpu_wdata;
      end
      case (state)
        LOOKUP: begin
          if (!req_we && hit) begin
            bus.o_cpu_ack   <= 1'b1;
            bus.o_cpu_rdata <= bus.i_dat_r;
          end else begin
            // Memory request is launched from a register so it stays stable until acked.
            bus.o_mem_req   <= 1'b1;
            bus.o_mem_we    <= req_we;
            bus.o_mem_addr  <= req_addr;
            bus.o_mem_wdata <= req_we ? req_wdata : '0;
          end
        end
        REFILL: begin
          if (bus.i_mem_ack) begin
            bus.o_mem_req    <= 1'b0;
            valid[req_index] <= 1'b1;
            bus.o_cpu_ack    <= 1'b1;
            bus.o_cpu_rdata  <= bus.i_mem_rdata;
          end
        end
        WRMEM: begin
          if (bus.i_mem_ack) begin
            bus.o_mem_req <= 1'b0;
            bus.o_mem_we  <= 1'b0;
            bus.o_cpu_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_cache_ctrl.sv
// Bench for sram_cache_ctrl: SRAM and backing-memory models plus a line-presence reference model.
module tb_sram_cache_ctrl;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int IW = 6;
  localparam int TW = AW - IW;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic ck;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 3;
  int   log_rd = 0;
  int   wait_cnt;
  bit   just_acked = 0;
  txn_t mem_log[$];

  bit            mvalid [64];
  logic [TW-1:0] mtag   [64];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] bm      [logic [AW-1:0]];

  logic [DW-1:0] dat_mem [64];
  logic [TW-1:0] tag_mem [64];
  logic          dp_v, tp_v;
  logic [IW-1:0] dp_a, tp_a;
  logic [DW-1:0] dp_d;
  logic [TW-1:0] tp_d;

  sram_cache_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

  sram_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .i_ck    (ck),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 30'h40) ? 32'hDEADBEEF : ({2'b10, a} ^ 32'h5A5A_0F0F);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] bm_rd(input logic [AW-1:0] a);
    return bm.exists(a) ? bm[a] : init_val(a);
  endfunction

  // SRAM: read data one cycle after the address; write commits one edge later, read-after-write sees it.
  always @(posedge ck) begin
    bus.i_dat_r <= (dp_v && dp_a == bus.o_dat_addr) ? dp_d : dat_mem[bus.o_dat_addr];
    bus.i_tag_r <= (tp_v && tp_a == bus.o_tag_addr) ? tp_d : tag_mem[bus.o_tag_addr];
    if (dp_v) dat_mem[dp_a] <= dp_d;
    if (tp_v) tag_mem[tp_a] <= tp_d;
    dp_v <= bus.o_dat_we;
    dp_a <= bus.o_dat_addr;
    dp_d <= bus.o_dat_w;
    tp_v <= bus.o_tag_we;
    tp_a <= bus.o_tag_addr;
    tp_d <= bus.o_tag_w;
  end

  // Backing memory: acks mem_lat cycles after it first sees a request.
  initial begin
    txn_t t;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    wait_cnt        = 0;
    forever begin
      @(negedge ck);
      bus.i_mem_ack = 1'b0;
      if (!rst_n || !bus.o_mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= mem_lat) begin
        t.we    = bus.o_mem_we;
        t.addr  = bus.o_mem_addr;
        t.wdata = bus.o_mem_wdata;
        mem_log.push_back(t);
        if (t.we) bm[t.addr] = t.wdata;
        else bus.i_mem_rdata = bm_rd(t.addr);
        bus.i_mem_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int gap, input bit with_flush);
    int            idx;
    int            lat;
    int            exp_n;
    bit            exp_hit;
    bit            acked;
    logic [TW-1:0] tag;
    txn_t          t;
    if (gap > 0) begin
      bus.i_cpu_req = 1'b0;
      @(negedge ck);
      check("ack_one_cycle", bus.o_cpu_ack, 0);
      for (int i = 1; i < gap; i++) @(negedge ck);
      just_acked = 0;
    end
    idx = int'(addr[IW-1:0]);
    tag = addr[AW-1:IW];
    if (with_flush) model_flush();
    exp_hit = mvalid[idx] && (mtag[idx] == tag);

    bus.i_cpu_req   = 1'b1;
    bus.i_cpu_we    = we;
    bus.i_cpu_addr  = addr;
    bus.i_cpu_wdata = wdata;
    bus.i_flush     = with_flush;
    lat   = 0;
    acked = 0;
    while (!acked && lat < 200) begin
      @(negedge ck);
      bus.i_flush = 1'b0;
      lat++;
      if (bus.o_cpu_ack) acked = 1;
    end
    check("ack_seen", acked, 1);
    bus.i_cpu_req = 1'b0;

    if (!we) check("rdata", bus.o_cpu_rdata, ref_rd(addr));
    if (!we && exp_hit) check("hit_latency", lat, (just_acked && !with_flush) ? 3 : 2);
    exp_n = (!we && exp_hit) ? 0 : 1;
    check("mem_txn_count", mem_log.size() - log_rd, exp_n);
    if (mem_log.size() > log_rd) begin
      t = mem_log[log_rd];
      log_rd = mem_log.size();
      check("mem_we", t.we, we);
      check("mem_addr", t.addr, addr);
      if (we) check("mem_wdata", t.wdata, wdata);
    end

    if (we) ref_mem[addr] = wdata;
    else if (!exp_hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
    end
    just_acked = 1;
  endtask

  initial begin
    bit got;
    rst_n           = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_cpu_req   = 1'b0;
    bus.i_cpu_we    = 1'b0;
    bus.i_cpu_addr  = '0;
    bus.i_cpu_wdata = '0;
    model_flush();
    repeat (3) @(negedge ck);
    check("rst_cpu_ack", bus.o_cpu_ack, 0);
    check("rst_cpu_rdata", bus.o_cpu_rdata, 0);
    check("rst_mem_req", bus.o_mem_req, 0);
    check("rst_mem_addr", bus.o_mem_addr, 0);
    check("rst_dat_we", bus.o_dat_we, 0);
    check("rst_tag_we", bus.o_tag_we, 0);
    check("rst_dat_addr", bus.o_dat_addr, 0);
    rst_n = 1'b1;
    @(negedge ck);

    // First read of 0x40 misses and refills from memory after 3 cycles.
    mem_lat = 3;
    do_access(1'b0, 30'h40, '0, 1, 0);
    do_access(1'b0, 30'h40, '0, 1, 0);
    check("dat_sram_0", dat_mem[0], 32'hDEADBEEF);
    check("tag_sram_0", tag_mem[0], 1);

    do_access(1'b1, 30'h40, 32'h12345678, 1, 0);
    check("dat_sram_wr", dat_mem[0], 32'h12345678);
    do_access(1'b0, 30'h40, '0, 0, 0);

    // Write miss leaves the cached line alone.
    do_access(1'b1, 30'h80, 32'hCAFEF00D, 1, 0);
    do_access(1'b0, 30'h40, '0, 1, 0);
    do_access(1'b0, 30'h80, '0, 1, 0);

    // Same-index conflict.
    do_access(1'b0, 30'h00, '0, 1, 0);
    do_access(1'b0, 30'h40, '0, 1, 0);
    do_access(1'b0, 30'h00, '0, 1, 0);

    // Flush together with a request, then the request misses.
    do_access(1'b0, 30'h40, '0, 1, 0);
    do_access(1'b0, 30'h40, '0, 1, 1);

    // Async reset while a refill is outstanding.
    mem_lat = 10;
    bus.i_cpu_req  = 1'b1;
    bus.i_cpu_we   = 1'b0;
    bus.i_cpu_addr = 30'h05;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge ck);
      if (bus.o_mem_req) got = 1;
    end
    check("refill_mem_req", got, 1);
    #2 rst_n = 1'b0;
    bus.i_cpu_req = 1'b0;
    #1;
    check("async_mem_req_drop", bus.o_mem_req, 0);
    check("async_cpu_ack", bus.o_cpu_ack, 0);
    @(negedge ck);
    rst_n = 1'b1;
    model_flush();
    just_acked = 0;
    mem_lat = 2;
    do_access(1'b0, 30'h40, '0, 1, 0);
    do_access(1'b0, 30'h05, '0, 0, 0);

    // Random traffic over a small address set to provoke hits, conflicts and flushes.
    for (int n = 0; n < 120; n++) begin
      logic [AW-1:0] a;
      a = AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, 3));
      mem_lat = $urandom_range(0, 4);
      do_access(1'($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 2),
                $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_cache_ctrl.md
Name: sram_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between one CPU word port and a slow backing-memory port.
- Drives two external sram_cache instances: a data array (DATA_WIDTH wide) and a tag array (TAG_WIDTH wide), each with 2**INDEX_WIDTH entries.
- Valid bits are kept in internal flops, because the SRAM models have no reset.

Parameters:
ADDR_WIDTH, 30, word address width (CPU and memory side)
DATA_WIDTH, 32, data word width
INDEX_WIDTH, 6, cache index bits; TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH

Ports:
i_ck  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  invalidate all lines (pulse)
i_cpu_req  in  1  CPU request; addr/we/wdata held stable until o_cpu_ack
i_cpu_we  in  1  1 = write, 0 = read
i_cpu_addr  in  ADDR_WIDTH  word address
i_cpu_wdata  in  DATA_WIDTH  write data
o_cpu_rdata  out  DATA_WIDTH  read data, valid while o_cpu_ack=1 on reads
o_cpu_ack  out  1  one-cycle completion pulse
o_mem_req  out  1  backing-memory request, held until i_mem_ack
o_mem_we  out  1  backing-memory write
o_mem_addr  out  ADDR_WIDTH  backing-memory address
o_mem_wdata  out  DATA_WIDTH  backing-memory write data
i_mem_rdata  in  DATA_WIDTH  backing-memory read data, valid with i_mem_ack
i_mem_ack  in  1  backing-memory completion (one cycle)
o_dat_addr  out  INDEX_WIDTH  data SRAM address
o_dat_we  out  1  data SRAM write enable
o_dat_w  out  DATA_WIDTH  data SRAM write data
i_dat_r  in  DATA_WIDTH  data SRAM read data
o_tag_addr  out  INDEX_WIDTH  tag SRAM address
o_tag_we  out  1  tag SRAM write enable
o_tag_w  out  TAG_WIDTH  tag SRAM write data
i_tag_r  in  TAG_WIDTH  tag SRAM read data

Behaviour:
- SRAM timing contract:
  - Address presented in cycle T; read data on i_*_r in T+1.
  - Write presented in T commits at the end of T+1.
  - A read presented in T+1 or later returns the new data.
- Address split: index = addr[INDEX_WIDTH-1:0]; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH].
- Reset (async, i_rst_n=0):
  - State = IDLE; all valid bits = 0; request latches = 0.
  - All outputs 0: o_cpu_ack, o_cpu_rdata, o_mem_*, o_dat_*, o_tag_*.
- IDLE:
  - If i_flush=1: clear all valid bits this edge and stay IDLE. A concurrent i_cpu_req is not accepted this cycle.
  - Else if i_cpu_req=1: latch addr/we/wdata, drive o_dat_addr and o_tag_addr = index, go to LOOKUP.
- LOOKUP: hit = valid[index] && (i_tag_r == latched tag).
  - Read hit: o_cpu_ack=1, o_cpu_rdata=i_dat_r, go to IDLE. Latency is 2 cycles from the request-accept edge.
  - Read miss: go to REFILL.
  - Write hit: o_dat_we=1, o_dat_addr=index, o_dat_w=wdata, go to WRMEM.
  - Write miss: no SRAM or valid update, go to WRMEM.
- REFILL:
  - Drive o_mem_req=1, o_mem_we=0, o_mem_addr=latched addr.
  - On i_mem_ack, in that same cycle: o_dat_we=1 with i_mem_rdata; o_tag_we=1 with tag; set valid[index]; o_cpu_ack=1 with o_cpu_rdata=i_mem_rdata. Go to IDLE.
- WRMEM:
  - Drive o_mem_req=1, o_mem_we=1, o_mem_addr and o_mem_wdata from the latched request.
  - On i_mem_ack: o_cpu_ack=1, go to IDLE.
- o_mem_* and o_cpu_rdata are registered-stable for the whole request; o_cpu_ack is exactly one cycle.
- i_flush outside IDLE is ignored. It must be re-pulsed in IDLE.
- i_cpu_req still high in the cycle after ack is a new request.
- Back-to-back access to a just-refilled or just-written index must hit correctly. The SRAM timing contract guarantees this; no bypass is needed.
- Reset asserted mid-REFILL/WRMEM:
  - o_mem_req drops immediately (async) and the request is abandoned.
  - SRAM contents are untouched, but all lines become invalid.

Test Plan:
- Reset, then read addr 0x40 with memory returning 0xDEADBEEF after 3 cycles -> mem_req/we=0/addr=0x40 held until ack; o_cpu_ack with 0xDEADBEEF; tag/data SRAM written at index 0.
- Re-read 0x40 immediately after ack -> hit; ack exactly 2 cycles after accept; rdata 0xDEADBEEF; no o_mem_req.
- Write 0x40 = 0x12345678 (hit) -> data SRAM written in LOOKUP; mem write 0x12345678 to 0x40; then read 0x40 hits and returns 0x12345678.
- Write miss to 0x80 (index 0, different tag) -> memory write only; then read 0x40 still hits with 0x12345678; read 0x80 misses and refills.
- Conflict: read 0x00 then read 0x40 (same index) -> second is a miss that replaces the tag; a following read of 0x00 misses.
- i_flush in IDLE together with i_cpu_req -> request not accepted that cycle; next read of 0x40 misses. Async reset during REFILL -> o_mem_req=0 immediately; first access after reset misses.
